// File: rtl/sha_pad_stream_pkg.sv
// Shared constants for the SHA padding stream: FSM states, block geometry, length-field slots.
package sha_const;
  typedef enum logic [2:0] {IDLE, DATA, PAD, ZERO, LEN} state_t;

  localparam int BLOCK_WORDS = 16;
  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam logic [IDX_W-1:0] LEN_HI_IDX = IDX_W'(14);
  localparam logic [IDX_W-1:0] LEN_LO_IDX = IDX_W'(15);
endpackage

// File: rtl/sha_pad_stream_if.sv
// Word stream in, padded 16-word blocks out; both sides use valid/ready.
interface sha_pad_stream_if #(
  parameter int W = 32
) ();
  logic                   Init;
  logic [W-1:0]           In_Data;
  logic                   In_Valid;
  logic                   In_Ready;
  logic                   In_Last;
  logic [$clog2(W/8):0]   In_Bytes;
  logic [W-1:0]           Out_Data;
  logic [3:0]             Out_Index;
  logic                   Out_Valid;
  logic                   Out_Ready;
  logic                   Out_Final;

  modport master (
    output Init, In_Data, In_Valid, In_Last, In_Bytes, Out_Ready,
    input  In_Ready, Out_Data, Out_Index, Out_Valid, Out_Final
  );

  modport slave (
    input  Init, In_Data, In_Valid, In_Last, In_Bytes, Out_Ready,
    output In_Ready, Out_Data, Out_Index, Out_Valid, Out_Final
  );
endinterface

// File: rtl/sha_pad_word.sv
// Keeps the first k bytes of a big-endian word, puts 0x80 at byte k and zeros after it.
// Non-last words pass through untouched; a byte count above NB is clamped to NB.
module sha_pad_word #(
  parameter int W = 32
) (
  input  logic [W-1:0]          data,
  input  logic                  last,
  input  logic [$clog2(W/8):0]  bytes,
  output logic [W-1:0]          word,
  output logic [$clog2(W/8):0]  k,
  output logic                  full
);
  localparam int NB = W / 8;
  localparam int BW = $clog2(NB) + 1;

  always_comb begin
    word = '0;
    k    = BW'(NB);
    if (last && (bytes < BW'(NB))) k = bytes;
    full = (k == BW'(NB));
    for (int i = 0; i < NB; i++) begin
      if (i < int'(k))       word[W-1-8*i -: 8] = data[W-1-8*i -: 8];
      else if (i == int'(k)) word[W-1-8*i -: 8] = 8'h80;
    end
  end
endmodule

// File: rtl/sha_pad_stream.sv
// SHA message padder: one output register stage (latency 1), input stalls while output is held.
// Optional sticky Error output when SHA_PAD_ERROR_EN is defined.
module sha_pad_stream
  import sha_const::*;
#(
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              rst,
  sha_pad_stream_if.slave   bus
`ifdef SHA_PAD_ERROR_EN
  ,
  output logic              Error
`endif
);
  localparam int NB = W / 8;
  localparam int LW = 2 * W;
  localparam int BW = $clog2(NB) + 1;

  state_t             state, state_nx;
  logic [W-1:0]       dat_q, dat_nx;
  logic [IDX_W-1:0]   oidx_q, oidx_nx, idx_q, idx_nx;
  logic               vld_q, vld_nx, fin_q, fin_nx;
  logic [LW-1:0]      len_q, len_nx;
  logic               adv, in_xfer;
  logic [W-1:0]       pad_dat;
  logic [BW-1:0]      pad_k;
  logic               pad_full;

  sha_pad_word #(.W(W)) u_word (
    .data  (bus.In_Data),
    .last  (bus.In_Last),
    .bytes (bus.In_Bytes),
    .word  (pad_dat),
    .k     (pad_k),
    .full  (pad_full)
  );

  assign adv           = !vld_q || bus.Out_Ready;
  assign bus.In_Ready  = (state == DATA) && adv && !bus.Init;
  assign in_xfer       = bus.In_Ready && bus.In_Valid;
  assign bus.Out_Data  = dat_q;
  assign bus.Out_Index = oidx_q;
  assign bus.Out_Valid = vld_q;
  assign bus.Out_Final = fin_q;

  always_comb begin
    state_nx = state;
    dat_nx   = dat_q;
    oidx_nx  = oidx_q;
    idx_nx   = idx_q;
    vld_nx   = vld_q && !bus.Out_Ready;
    fin_nx   = fin_q;
    len_nx   = len_q;
    if (bus.Init) begin
      state_nx = DATA;
      idx_nx   = '0;
      len_nx   = '0;
      vld_nx   = 1'b0;
      fin_nx   = 1'b0;
    end else if (adv) begin
      case (state)
        DATA: if (in_xfer) begin
          dat_nx  = pad_dat;
          oidx_nx = idx_q;
          idx_nx  = idx_q + 1'b1;
          vld_nx  = 1'b1;
          fin_nx  = 1'b0;
          len_nx  = len_q + (LW'(pad_k) << 3);
          if (bus.In_Last) state_nx = pad_full ? PAD : ZERO;
        end
        PAD: begin
          dat_nx   = {8'h80, {(W-8){1'b0}}};
          oidx_nx  = idx_q;
          idx_nx   = idx_q + 1'b1;
          vld_nx   = 1'b1;
          state_nx = ZERO;
        end
        // Entering with index 14 means the 0x80 word sat at 13: go straight to the length.
        ZERO: if (idx_q == LEN_HI_IDX) begin
          state_nx = LEN;
        end else begin
          dat_nx  = '0;
          oidx_nx = idx_q;
          idx_nx  = idx_q + 1'b1;
          vld_nx  = 1'b1;
          if (idx_q == LEN_HI_IDX - 1'b1) state_nx = LEN;
        end
        LEN: if (vld_q && fin_q) begin
          state_nx = IDLE;
        end else begin
          dat_nx  = (idx_q == LEN_HI_IDX) ? len_q[LW-1:W] : len_q[W-1:0];
          oidx_nx = idx_q;
          idx_nx  = idx_q + 1'b1;
          vld_nx  = 1'b1;
          fin_nx  = (idx_q == LEN_LO_IDX);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      dat_q  <= '0;
      oidx_q <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      fin_q  <= 1'b0;
      len_q  <= '0;
    end else begin
      state  <= state_nx;
      dat_q  <= dat_nx;
      oidx_q <= oidx_nx;
      idx_q  <= idx_nx;
      vld_q  <= vld_nx;
      fin_q  <= fin_nx;
      len_q  <= len_nx;
    end
  end

`ifdef SHA_PAD_ERROR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      Error <= 1'b0;
    else if (bus.Init)
      Error <= 1'b0;
    else if (bus.In_Valid && ((bus.In_Last && (bus.In_Bytes > BW'(NB))) || (state == IDLE)))
      Error <= 1'b1;
  end
`endif
endmodule
